// File: rtl/complex_numeral_pkg.sv
// Shared types and helpers for the base (i-1) complex-numeral datapath.
package complex_numeral_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        longint re;
        longint im;
    } gauss_t;

    // One Horner step z <- z*(i-1) + d at unbounded precision.
    function automatic gauss_t horner_update(input gauss_t z, input logic d);
        gauss_t r;
        r.re = -z.re - z.im + longint'(d);
        r.im = z.re - z.im;
        return r;
    endfunction

    // |z| grows by sqrt(2) per digit, so DIGITS/2 bits plus sign and margin suffice.
    function automatic bit width_ok(input int digits, input int w);
        return w >= digits / 2 + 4;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared by the complex-numeral arithmetic.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/horner_step.sv
// Combinational base (i-1) Horner update: a' = -a - b + d, b' = a - b.
// BASEIM1_OVF_EN widens the adders by two bits and flags results outside W bits.
module horner_step #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         d,
    output logic [W-1:0] a_next,
    output logic [W-1:0] b_next
`ifdef BASEIM1_OVF_EN
    ,
    output logic         ovf
`endif
);
`ifdef BASEIM1_OVF_EN
    localparam int XW = W + 2;
`else
    localparam int XW = W;
`endif

    logic [XW-1:0] ax, bx, sum_ab, an, bn, d_ext;
    logic [XW:0]   c_sum, c_an, c_bn;
    logic          unused_carry;

    assign ax    = XW'($signed(a));
    assign bx    = XW'($signed(b));
    assign d_ext = {{(XW-1){1'b0}}, d};

    // -(a+b) + d is computed as ~(a+b) + d + 1, and a - b as a + ~b + 1.
    assign c_sum[0] = 1'b0;
    assign c_an[0]  = 1'b1;
    assign c_bn[0]  = 1'b1;

    for (genvar i = 0; i < XW; i++) begin : g_bit
        full_adder u_sum (.a(ax[i]),      .b(bx[i]),    .ci(c_sum[i]), .s(sum_ab[i]), .co(c_sum[i+1]));
        full_adder u_an  (.a(~sum_ab[i]), .b(d_ext[i]), .ci(c_an[i]),  .s(an[i]),     .co(c_an[i+1]));
        full_adder u_bn  (.a(ax[i]),      .b(~bx[i]),   .ci(c_bn[i]),  .s(bn[i]),     .co(c_bn[i+1]));
    end

    assign unused_carry = c_sum[XW] ^ c_an[XW] ^ c_bn[XW];

    assign a_next = an[W-1:0];
    assign b_next = bn[W-1:0];

`ifdef BASEIM1_OVF_EN
    // In range only when the top three bits are a pure sign extension.
    assign ovf = !((&an[XW-1:W-1]) || !(|an[XW-1:W-1]))
              || !((&bn[XW-1:W-1]) || !(|bn[XW-1:W-1]));
`endif
endmodule

// File: rtl/base_im1_decoder.sv
// Bit-serial base (i-1) numeral decoder, MSD first, Horner accumulation.
// Optional BASEIM1_OVF_EN adds a sticky accumulator overflow flag.
module base_im1_decoder
    import complex_numeral_pkg::*;
#(
    parameter int DIGITS = 16,
    parameter int W      = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_digit,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_re,
    output logic [W-1:0]                 out_im,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndig,
    output logic                         out_trunc,
    output logic                         ovf
);
    localparam int NW = $clog2(DIGITS + 1);

    state_t        state;
    logic [W-1:0]  acc_a, acc_b, nxt_a, nxt_b;
    logic [NW-1:0] ndig;
    logic          trunc;
    logic          accept, at_max;

`ifdef BASEIM1_OVF_EN
    logic step_ovf;
    logic ovf_r;
`endif

    horner_step #(.W(W)) u_step (
        .a      (acc_a),
        .b      (acc_b),
        .d      (in_digit),
        .a_next (nxt_a),
        .b_next (nxt_b)
`ifdef BASEIM1_OVF_EN
        ,
        .ovf    (step_ovf)
`endif
    );

    assign accept = in_valid && (state == ACC);
    assign at_max = (ndig == NW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
            acc_a <= '0;
            acc_b <= '0;
            ndig  <= '0;
            trunc <= 1'b0;
        end else begin
            case (state)
                ACC: if (accept) begin
                    acc_a <= nxt_a;
                    acc_b <= nxt_b;
                    ndig  <= ndig + 1'b1;
                    if (in_last || at_max) begin
                        state <= HOLD;
                        trunc <= at_max && !in_last;
                    end
                end
                HOLD: if (out_ready) begin
                    state <= ACC;
                    acc_a <= '0;
                    acc_b <= '0;
                    ndig  <= '0;
                    trunc <= 1'b0;
                end
                default: state <= ACC;
            endcase
        end
    end

`ifdef BASEIM1_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_r <= 1'b0;
        else if (state == HOLD && out_ready)
            ovf_r <= 1'b0;
        else if (accept && step_ovf)
            ovf_r <= 1'b1;
    end
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    // Handshake flags derive from the registered state only.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign out_re    = acc_a;
    assign out_im    = acc_b;
    assign out_ndig  = ndig;
    assign out_trunc = trunc;
endmodule

// File: tb/tb_base_im1_decoder.sv
// Self-checking bench for base_im1_decoder: vector table, corner sequences,
// randomized frames against a power-sum model of base (i-1) numerals.
module tb_base_im1_decoder;
    localparam int DIGITS = 16;
    localparam int W      = 12;
    localparam int NW     = $clog2(DIGITS + 1);
    localparam int SW     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_digit, in_last;
    logic          out_valid, out_ready, out_trunc, ovf;
    logic [W-1:0]  out_re, out_im;
    logic [NW-1:0] out_ndig;

    logic          s_in_valid, s_in_ready, s_in_digit, s_in_last;
    logic          s_out_valid, s_out_ready, s_out_trunc, s_ovf;
    logic [SW-1:0] s_out_re, s_out_im;
    logic [NW-1:0] s_out_ndig;

    base_im1_decoder #(.DIGITS(DIGITS), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_ndig(out_ndig), .out_trunc(out_trunc), .ovf(ovf)
    );

    base_im1_decoder #(.DIGITS(DIGITS), .W(SW)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_digit(s_in_digit), .in_last(s_in_last), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_re(s_out_re), .out_im(s_out_im),
        .out_ndig(s_out_ndig), .out_trunc(s_out_trunc), .ovf(s_ovf)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          n;
        logic [15:0] digs;   // digit n-1 is sent first
        int          re;
        int          im;
    } vec_t;

    function automatic void check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic longint wrapw(input longint v, input int w);
        longint m = longint'(1) << w;
        longint r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Value = sum of d_k * (i-1)^k, powers built by repeated complex multiply.
    task automatic model(input bit q[$], output longint re, output longint im);
        longint pr = 1, pi = 0, t;
        int n = q.size();
        re = 0; im = 0;
        for (int k = 0; k < n; k++) begin
            if (q[n-1-k]) begin re += pr; im += pi; end
            t  = -pr - pi;
            pi = pr - pi;
            pr = t;
        end
    endtask

    task automatic send_frame(input bit q[$], input int idle, input bit mark_last);
        for (int j = 0; j < q.size(); j++) begin
            int guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 40) begin @(negedge clk); guard++; end
            if (!in_ready) check("in_ready_timeout", 0, 1);
            in_valid = 1'b1;
            in_digit = q[j];
            in_last  = mark_last && (j == q.size() - 1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (j != q.size() - 1)
                for (int k = 0; k < idle; k++) @(negedge clk);
        end
        // Now at the negedge one cycle after the final accept.
    endtask

    task automatic check_result(input string tag, input bit q[$], input bit exp_trunc);
        longint re, im;
        model(q, re, im);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_re"},   $signed(out_re), wrapw(re, W));
        check({tag, "_im"},   $signed(out_im), wrapw(im, W));
        check({tag, "_ndig"}, out_ndig, q.size());
        check({tag, "_trunc"}, out_trunc, exp_trunc);
        check({tag, "_ovf"},  ovf, 0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 0);
        check({tag, "_ready_again"}, in_ready, 1);
    endtask

    initial begin
        vec_t vt[4];
        bit   q[$];
        logic [SW-1:0] sv_re, sv_im;

        vt[0] = '{4, 16'b1100,  2, 0};
        vt[1] = '{5, 16'b11101, -1, 0};
        vt[2] = '{2, 16'b11,    0, 1};
        vt[3] = '{1, 16'b1,     1, 0};

        in_valid = 0; in_digit = 0; in_last = 0; out_ready = 0;
        s_in_valid = 0; s_in_digit = 0; s_in_last = 0; s_out_ready = 0;
        rst = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_ndig", out_ndig, 0);
        check("rst_trunc", out_trunc, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors with back-to-back digits; expected values are hand-derived.
        for (int v = 0; v < 4; v++) begin
            q = {};
            for (int j = vt[v].n - 1; j >= 0; j--) q.push_back(vt[v].digs[j]);
            send_frame(q, 0, 1);
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_re", v), $signed(out_re), vt[v].re);
            check($sformatf("vec%0d_im", v), $signed(out_im), vt[v].im);
            check($sformatf("vec%0d_ndig", v), out_ndig, vt[v].n);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check($sformatf("vec%0d_release", v), out_valid, 0);
        end

        // Idle gaps, then a stalled consumer with in_valid pushed during HOLD.
        q = {1, 1, 0, 1};
        send_frame(q, 3, 1);
        in_valid = 1'b1; in_digit = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("hold_in_ready", in_ready, 0);
            check("hold_valid", out_valid, 1);
            check("hold_re", $signed(out_re), 3);
            check("hold_im", $signed(out_im), 0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_digit = 1'b0;
        check("hold_ndig", out_ndig, 4);
        consume("hold");

        // Forced termination at DIGITS without in_last.
        q = {};
        for (int j = 0; j < DIGITS; j++) q.push_back(bit'($urandom_range(0, 1)));
        send_frame(q, 0, 0);
        check_result("trunc", q, 1);
        consume("trunc");

        // Abort a partial frame with rst, then a clean frame.
        q = {1, 1};
        send_frame(q, 0, 0);
        rst = 1'b1;
        #1;
        check("abort_ndig", out_ndig, 0);
        check("abort_re", out_re, 0);
        check("abort_im", out_im, 0);
        @(negedge clk);
        rst = 1'b0;
        q = {1, 1, 0, 0};
        send_frame(q, 0, 1);
        check("after_abort_re", $signed(out_re), 2);
        check("after_abort_im", $signed(out_im), 0);
        check("after_abort_ndig", out_ndig, 4);
        consume("after_abort");

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int  n    = $urandom_range(1, DIGITS);
            bit  mark = (n < DIGITS) ? 1'b1 : bit'($urandom_range(0, 1));
            q = {};
            for (int j = 0; j < n; j++) q.push_back(bit'($urandom_range(0, 1)));
            send_frame(q, $urandom_range(0, 2), mark);
            check_result($sformatf("rnd%0d", f), q, !mark);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) @(negedge clk);
            consume($sformatf("rnd%0d", f));
        end

        // Narrow instance: 1000000 drives im to 8, outside 4-bit range.
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_in_digit = (j == 0);
            s_in_last  = (j == 6);
            @(negedge clk);
            s_in_valid = 1'b0;
            s_in_last  = 1'b0;
        end
        sv_re = s_out_re;
        sv_im = s_out_im;
        check("small_valid", s_out_valid, 1);
        check("small_re", sv_re, 4'd0);
        check("small_im", sv_im, 4'b1000);
        check("small_ndig", s_out_ndig, 7);
`ifdef BASEIM1_OVF_EN
        check("small_ovf", s_ovf, 1);
`else
        check("small_ovf", s_ovf, 0);
`endif
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        check("small_ovf_cleared", s_ovf, 0);
        check("small_released", s_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
